// File: rtl/mod_addsub_seq.sv
// Sequenced modular adder/subtractor r = (a +/- b) mod p over a shared CW-bit adder cell.
// Pass 1 forms a +/- b, pass 2 forms the modulus correction; the result is selected from the two carries.
module mod_addsub_seq #(
    parameter int N  = 256,
    parameter int CW = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] p,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] r
);

    localparam int CHUNKS = N / CW;
    localparam int CNTW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t          state, state_nx;
    logic [CNTW-1:0] cnt;
    logic            last;
    logic            accept;
    logic            opr, carry, c1, c2;
    logic [N-1:0]    sa, sb, sp, t, u;
    logic [CW-1:0]   x, y;
    logic            cin;
    logic [CW:0]     sum;
    logic [N-1:0]    sum_top, t_shift, t_rot, u_next, r_sel;

    assign last   = (cnt == CNTW'(CHUNKS - 1));
    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == PASS1) || (state == PASS2);
    assign done   = (state == DONE);

    // Shared adder cell: pass 1 consumes a/b, pass 2 consumes t/p.
    always_comb begin
        x   = sa[CW-1:0];
        y   = opr ? ~sb[CW-1:0] : sb[CW-1:0];
        cin = (cnt == '0) ? opr : carry;
        if (state == PASS2) begin
            x   = t[CW-1:0];
            y   = opr ? sp[CW-1:0] : ~sp[CW-1:0];
            cin = (cnt == '0) ? ~opr : carry;
        end
    end

    assign sum     = {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, cin};
    assign c2      = sum[CW];
    assign sum_top = N'(sum[CW-1:0]) << (N - CW);
    assign t_shift = (t >> CW) | sum_top;
    // t is rotated during pass 2 so it is whole again when the result is selected.
    assign t_rot   = (t >> CW) | (N'(t[CW-1:0]) << (N - CW));
    assign u_next  = (u >> CW) | sum_top;

    always_comb begin
        r_sel = t_rot;
        if (opr) begin
            if (!c1)
                r_sel = u_next;
        end else if (c1 || c2) begin
            r_sel = u_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = PASS1;
            PASS1:   if (last) state_nx = PASS2;
            PASS2:   if (last) state_nx = DONE;
            DONE:    state_nx = start ? PASS1 : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            opr   <= 1'b0;
            carry <= 1'b0;
            c1    <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            sp    <= '0;
            t     <= '0;
            u     <= '0;
            r     <= '0;
        end else if (accept) begin
            opr   <= op;
            sa    <= a;
            sb    <= b;
            sp    <= p;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                PASS1: begin
                    sa    <= sa >> CW;
                    sb    <= sb >> CW;
                    t     <= t_shift;
                    carry <= sum[CW];
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last)
                        c1 <= sum[CW];
                end
                PASS2: begin
                    sp    <= sp >> CW;
                    t     <= t_rot;
                    u     <= u_next;
                    carry <= sum[CW];
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last)
                        r <= r_sel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Bench for mod_addsub_seq: directed handshake/boundary steps on CW=64, then a random
// sweep of four chunk widths sharing one stimulus against an arithmetic reference.
module tb_mod_addsub_seq;

    localparam int N = 256;
    localparam logic [N-1:0] SM2P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    logic         clk = 1'b0;
    logic         rst, start, op;
    logic [N-1:0] a, b, p;
    logic         busyq [4];
    logic         doneq [4];
    logic [N-1:0] rq    [4];
    int           cws   [4] = '{64, 256, 32, 8};

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    mod_addsub_seq #(.N(N), .CW(64))  u64  (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .p(p),
                                            .busy(busyq[0]), .done(doneq[0]), .r(rq[0]));
    mod_addsub_seq #(.N(N), .CW(256)) u256 (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .p(p),
                                            .busy(busyq[1]), .done(doneq[1]), .r(rq[1]));
    mod_addsub_seq #(.N(N), .CW(32))  u32  (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .p(p),
                                            .busy(busyq[2]), .done(doneq[2]), .r(rq[2]));
    mod_addsub_seq #(.N(N), .CW(8))   u8   (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .p(p),
                                            .busy(busyq[3]), .done(doneq[3]), .r(rq[3]));

    function automatic logic [N-1:0] ref_modop(input logic o, input logic [N-1:0] x, y, m);
        logic [N:0] s;
        if (!o) begin
            s = {1'b0, x} + {1'b0, y};
            if (s >= {1'b0, m})
                s = s - {1'b0, m};
        end else if (x >= y) begin
            s = {1'b0, x} - {1'b0, y};
        end else begin
            s = {1'b0, x} + {1'b0, m} - {1'b0, y};
        end
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_below_p();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++)
            v[i*32 +: 32] = $urandom;
        if (v >= SM2P)
            v = v - SM2P;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation on the CW=64 instance; latency counts edges from raising start to seeing done.
    task automatic run0(input logic o, input logic [N-1:0] x, y,
                        output logic [N-1:0] res, output int lat, output int bc);
        op = o; a = x; b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        bc  = 0;
        while (!doneq[0] && lat < 200) begin
            if (busyq[0]) bc++;
            tick();
            lat++;
        end
        res = rq[0];
    endtask

    initial begin
        logic [N-1:0] res, ea, eb, exp;
        logic         eo;
        int           lat, bc, ndone;
        logic         seen [4];

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; p = SM2P;
        tick(); tick();
        chk_int("reset_busy", int'(busyq[0]), 0);
        chk_int("reset_done", int'(doneq[0]), 0);
        chk_vec("reset_r", rq[0], '0);
        rst = 1'b0;
        tick();

        run0(1'b0, 256'd1, 256'd2, res, lat, bc);
        chk_vec("add_1_2", res, 256'd3);
        chk_int("add_latency", lat, 9);
        chk_int("add_busy_cycles", bc, 8);
        tick();
        chk_int("done_one_cycle", int'(doneq[0]), 0);

        run0(1'b0, SM2P - 1, 256'd1, res, lat, bc);
        chk_vec("add_pm1_1", res, '0);
        run0(1'b0, SM2P - 1, SM2P - 1, res, lat, bc);
        chk_vec("add_pm1_pm1", res, SM2P - 2);
        run0(1'b1, 256'd0, 256'd1, res, lat, bc);
        chk_vec("sub_0_1", res, SM2P - 1);
        run0(1'b1, 256'd5, 256'd5, res, lat, bc);
        chk_vec("sub_5_5", res, '0);
        run0(1'b1, 256'd7, 256'd3, res, lat, bc);
        chk_vec("sub_7_3", res, 256'd4);

        // start during PASS1 must be ignored
        op = 1'b0; a = 256'd1; b = 256'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 256'd10; b = 256'd20; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 3;
        while (!doneq[0] && lat < 200) begin
            tick();
            lat++;
        end
        chk_vec("ignore_busy_start", rq[0], 256'd3);
        chk_int("ignore_busy_latency", lat, 9);

        // start held in the DONE cycle is accepted back-to-back
        a = 256'd7; b = 256'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk_int("b2b_done_drops", int'(doneq[0]), 0);
        chk_int("b2b_busy", int'(busyq[0]), 1);
        chk_vec("b2b_r_held", rq[0], 256'd3);
        lat = 1;
        while (!doneq[0] && lat < 200) begin
            tick();
            lat++;
        end
        chk_vec("b2b_result", rq[0], 256'd10);
        chk_int("b2b_latency", lat, 9);

        // reset during PASS2
        op = 1'b0; a = 256'd5; b = 256'd6; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_int("pre_reset_in_pass", int'(busyq[0]), 1);
        rst = 1'b1;
        #1;
        chk_int("midrst_busy", int'(busyq[0]), 0);
        chk_int("midrst_done", int'(doneq[0]), 0);
        chk_vec("midrst_r", rq[0], '0);
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (doneq[0]) ndone++;
        end
        chk_int("midrst_no_done", ndone, 0);
        run0(1'b0, 256'd1, 256'd2, res, lat, bc);
        chk_vec("post_rst_add", res, 256'd3);
        chk_int("post_rst_latency", lat, 9);

        // random sweep over all chunk widths
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int v = 0; v < 1000; v++) begin
            ea = rand_below_p();
            eb = rand_below_p();
            eo = 1'(($urandom >> 7) & 1);
            exp = ref_modop(eo, ea, eb, SM2P);
            op = eo; a = ea; b = eb;
            for (int j = 0; j < 4; j++) seen[j] = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            lat = 1;
            forever begin
                for (int j = 0; j < 4; j++) begin
                    if (doneq[j] && busyq[j]) chk_int("done_busy_overlap", 1, 0);
                    if (doneq[j] && !seen[j]) begin
                        seen[j] = 1'b1;
                        chk_vec($sformatf("sweep_r_cw%0d", cws[j]), rq[j], exp);
                        chk_int($sformatf("sweep_lat_cw%0d", cws[j]), lat, 2 * (N / cws[j]) + 1);
                    end
                end
                if ((seen[0] && seen[1] && seen[2] && seen[3]) || lat >= 200) break;
                tick();
                lat++;
            end
            for (int j = 0; j < 4; j++)
                if (!seen[j]) chk_int($sformatf("sweep_timeout_cw%0d", cws[j]), 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
